// File: rtl/perfect_memory_arbiter.sv
// Purpose: round-robin arbiter sharing one fixed-latency line-wide memory between N_REQ requesters.
// Latency: accept T, memory request T+1, response T+3+D (ready seen D cycles into WAIT), timeout at T+2+TIMEOUT.
// Backpressure: one transaction in flight; requests are held off while busy; responses are not backpressured.
module perfect_memory_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADDR_SIZE = 40,
  parameter int LINE_SIZE = 128,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*ADDR_SIZE-1:0] req_addr_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [N_REQ-1:0]           resp_valid_o,
  output logic [LINE_SIZE-1:0]       resp_line_o,
  output logic                       resp_error_o,
  output logic                       mem_valid_o,
  output logic [ADDR_SIZE-1:0]       mem_addr_o,
  input  logic                       mem_ready_i,
  input  logic [LINE_SIZE-1:0]       mem_line_i,
  output logic                       busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]     gnt_q, gnt_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LINE_SIZE-1:0] line_q, line_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     wait_cnt, wait_cnt_d;

  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     idx;
  logic                 win_found;
  logic [ADDR_SIZE-1:0] addr_arr [N_REQ];

  // Split the flat address bus into one entry per requester.
  for (genvar k = 0; k < N_REQ; k++) begin : g_addr
    assign addr_arr[k] = req_addr_i[k*ADDR_SIZE +: ADDR_SIZE];
  end

  // Round-robin search upward from rr_ptr, wrapping past N_REQ-1 to 0.
  always_comb begin
    win       = '0;
    idx       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  // Next-state logic and the combinational accept.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    line_d      = line_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt;
    req_ready_o = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready_o[win] = 1'b1;
          addr_d           = addr_arr[win];
          gnt_d            = win;
          rr_ptr_d         = PTR_W'((int'(win) + 1) % N_REQ);
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt != CNT_W'(TIMEOUT)) begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
        // First WAIT cycle ignores ready: the memory drops it one cycle after accepting.
        if ((wait_cnt != '0) && mem_ready_i) begin
          line_d  = mem_line_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          line_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr   <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      err_q    <= err_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Response pulse decoded from registered state only.
  always_comb begin
    resp_valid_o = '0;
    if (state_q == S_RESP) begin
      resp_valid_o[gnt_q] = 1'b1;
    end
  end

  assign resp_line_o  = line_q;
  assign resp_error_o = err_q;
  assign mem_valid_o  = (state_q == S_ISSUE);
  assign mem_addr_o   = addr_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_perfect_memory_arbiter.sv
// Directed bench for perfect_memory_arbiter with N_REQ=2 and TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// The bench plays the memory, holding ready low except for the chosen cycle.
module tb_perfect_memory_arbiter;

  localparam int TO = 8;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [79:0]  req_addr;
  logic [1:0]   req_ready;
  logic [1:0]   resp_valid;
  logic [127:0] resp_line;
  logic         resp_error;
  logic         mem_valid;
  logic [39:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_line;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  localparam logic [39:0]  A0 = 40'h00_1000_0040;
  localparam logic [39:0]  A1 = 40'h00_2000_0080;
  localparam logic [127:0] L0 = 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF;
  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] L2 = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;

  perfect_memory_arbiter #(
    .N_REQ(2), .ADDR_SIZE(40), .LINE_SIZE(128), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_line_o(resp_line), .resp_error_o(resp_error),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr),
    .mem_ready_i(mem_ready), .mem_line_i(mem_line),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in an IDLE cycle. d = cycle of WAIT (wait_cnt)
  // at which memory shows ready; d = 0 means memory never answers (timeout).
  task automatic txn(input logic [1:0] vld, input logic [1:0] late, input int d,
                     input logic [127:0] line, input logic [1:0] g, input logic [39:0] ea);
    int           t0;
    logic         err_e;
    logic [127:0] held;
    err_e     = (d == 0);
    req_valid = vld;
    req_addr  = {A1, A0};
    mem_ready = 1'b1;
    #1;
    chk("accept_ready", req_ready, g);
    chk("idle_busy", busy, 0);
    t0 = cyc;
    tick();
    chk("issue_mem_valid", mem_valid, 1);
    chk("issue_mem_addr", mem_addr, ea);
    chk("issue_ready", req_ready, 0);
    mem_ready = 1'b0;
    tick();
    chk("wait0_mem_valid", mem_valid, 0);
    // Ready during the first WAIT cycle must be ignored.
    mem_ready = 1'b1;
    mem_line  = 128'hBAD;
    req_valid = vld | late;
    #1;
    chk("wait0_ready", req_ready, 0);
    for (int c = 1; c <= TO - 1; c++) begin
      tick();
      mem_ready = (c == d);
      mem_line  = (c == d) ? line : 128'hBAD;
      #1;
      chk("wait_resp_valid", resp_valid, 0);
      chk("wait_mem_addr", mem_addr, ea);
      chk("wait_ready", req_ready, 0);
      if (c == d) break;
    end
    tick();
    chk("resp_valid", resp_valid, g);
    chk("resp_error", resp_error, err_e);
    chk("resp_line", resp_line, err_e ? 128'h0 : line);
    chk("resp_latency", cyc - t0, err_e ? TO + 2 : d + 3);
    chk("resp_busy", busy, 1);
    held      = resp_line;
    mem_ready = 1'b1;
    mem_line  = '1;
    tick();
    chk("post_resp_valid", resp_valid, 0);
    chk("post_resp_line_hold", resp_line, err_e ? 128'h0 : line);
    chk("post_resp_err_hold", resp_error, err_e);
    chk("post_resp_busy", busy, 0);
    if (held !== resp_line) $display("note: line changed after response");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_line"}, resp_line, 0);
    chk({tag, "_resp_error"}, resp_error, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    mem_ready = 1'b1;
    mem_line  = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single request from requester 0, D=1.
    txn(2'b01, 2'b00, 1, L0, 2'b01, A0);
    req_valid = '0;

    // Reset so round-robin starts from requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pulse_resp_line", resp_line, 0);

    // Both requesters held valid: grants alternate 0,1,0,1.
    txn(2'b11, 2'b00, 1, L0, 2'b01, A0);
    txn(2'b11, 2'b00, 2, L1, 2'b10, A1);
    txn(2'b11, 2'b00, 3, L2, 2'b01, A0);
    txn(2'b11, 2'b00, 1, L1, 2'b10, A1);
    req_valid = '0;

    // Requester 1 appears during requester 0's WAIT; accepted right after RESP.
    txn(2'b01, 2'b10, 2, L2, 2'b01, A0);
    txn(2'b10, 2'b00, 1, L0, 2'b10, A1);
    req_valid = '0;

    // Timeout, then a normal transaction.
    txn(2'b01, 2'b00, 0, L0, 2'b01, A0);
    txn(2'b01, 2'b00, 1, L1, 2'b01, A0);
    req_valid = '0;

    // Ready arrives exactly on the timeout cycle: data wins.
    txn(2'b10, 2'b00, TO - 1, L2, 2'b10, A1);
    req_valid = '0;

    // Reset mid-WAIT after granting requester 0 (rr_ptr would be 1).
    req_valid = 2'b01;
    req_addr  = {A1, A0};
    #1;
    chk("mid_accept_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_resp", resp_valid, 0);
    end
    txn(2'b11, 2'b00, 1, L0, 2'b01, A0);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/perfect_memory_arbiter.md
# perfect_memory_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency, line-wide perfect memory model between `N_REQ` requesters, such as instruction-fetch and data-refill ports, in the debug-ring testbench. It accepts one line request at a time, issues it to the memory, and waits for the memory to return to ready, bounded by a timeout. It then captures the line and returns it, tagged, to the granted requester.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `ADDR_SIZE`, 40: request address width.
- `LINE_SIZE`, 128: line data width.
- `TIMEOUT`, 64: maximum WAIT cycles before an error response (≥2).
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in N_REQ: per-requester request valid.
- `req_addr_i` in N_REQ×ADDR_SIZE: per-requester line address; requester k occupies bits [k*ADDR_SIZE +: ADDR_SIZE].
- `req_ready_o` out N_REQ: one-hot accept; at most one bit set.
- `resp_valid_o` out N_REQ: one-hot, one-cycle response pulse.
- `resp_line_o` out LINE_SIZE: response data, shared by all requesters.
- `resp_error_o` out 1: response terminated by timeout; `resp_line_o` = 0 in that case.
- `mem_valid_o` out 1: one-cycle request pulse to the memory.
- `mem_addr_o` out ADDR_SIZE: latched request address, held from ISSUE through RESP.
- `mem_ready_i` in 1: memory idle / data valid.
- `mem_line_i` in LINE_SIZE: memory read data, valid while `mem_ready_i`=1 after a request.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid_i` is set, the arbiter picks the winner g by round-robin, searching upward from `rr_ptr` with wrap-around at N_REQ-1 → 0.
  - `req_ready_o[g]`=1 combinationally in the same cycle.
  - It latches `addr_q`=`req_addr_i[g]` and `gnt_q`=g, sets `rr_ptr` to (g+1) mod N_REQ, and moves to ISSUE.
  - With no valid request it stays in IDLE; `rr_ptr` is unchanged.
- **ISSUE:**
  - `mem_valid_o`=1 for exactly this cycle, with `mem_addr_o`=`addr_q`.
  - Clears `wait_cnt` and moves to WAIT unconditionally.
- **WAIT:**
  - `wait_cnt` increments each cycle and saturates at TIMEOUT; its width is clog2(TIMEOUT)+1.
  - `mem_ready_i` is ignored while `wait_cnt`==0, which covers the memory's one-cycle ready drop after accepting.
  - If `wait_cnt`≥1 and `mem_ready_i`=1: capture `line_q`=`mem_line_i`, `err_q`=0, go to RESP.
  - Otherwise, if `wait_cnt`==TIMEOUT-1: `line_q`=0, `err_q`=1, go to RESP.
  - If ready and timeout occur in the same cycle, ready wins (`err_q`=0).
- **RESP:**
  - `resp_valid_o[gnt_q]`=1, `resp_line_o`=`line_q`, `resp_error_o`=`err_q`, all for one cycle.
  - Then go to IDLE. There is no backpressure; requesters must sink the response.
- **Request handling:**
  - A requester may drop `req_valid_i` while not granted; no state is kept for it.
  - Requests arriving while `busy_o`=1 are not accepted (`req_ready_o`=0) and must be held.
- `resp_line_o` and `resp_error_o` hold their last values outside RESP; they are qualified only by `resp_valid_o`.

## Timing
- **Reset (`rst_i`=1 at a clock edge):**
  - FSM goes to IDLE, `rr_ptr`=0, `addr_q`=0, `line_q`=0, `err_q`=0, `gnt_q`=0, `wait_cnt`=0.
  - Outputs: `req_ready_o`=0, `resp_valid_o`=0, `resp_line_o`=0, `resp_error_o`=0, `mem_valid_o`=0, `mem_addr_o`=0, `busy_o`=0.
  - Reset mid-transaction aborts it with no response. Asserting reset during RESP suppresses that cycle's response from the next edge on.
- **Latency:**
  - Accept at cycle T (IDLE), `mem_valid_o` at T+1, WAIT from T+2.
  - If `mem_ready_i` is first seen high (with `wait_cnt`≥1) at T+2+D, with D≥1, then `resp_valid_o` is at T+3+D.
  - Minimum accept-to-response is 4 cycles (D=1).
  - Timeout response is at T+2+TIMEOUT.
- **Throughput:** the next accept is at the earliest the cycle after RESP, i.e. one transaction per D+4 cycles.
- `req_ready_o` is a combinational function of FSM state, `req_valid_i` and `rr_ptr` only; it has no path from memory inputs.
- `mem_valid_o` and all `resp_*` outputs are registered-state decodes, glitch-free per cycle.

## Test plan
- **Single request:** req 0 at addr 0x1000_0040, memory D=1, `mem_line_i`=0xDEAD…BEEF → `mem_valid_o` one cycle with `mem_addr_o`=0x1000_0040; `resp_valid_o`=2'b01 four cycles after accept; `resp_line_o`=0xDEAD…BEEF; `resp_error_o`=0.
- **Round-robin:** both requesters hold valid continuously over 4 transactions → grants alternate 0,1,0,1; each response goes to the granted bit only; no request is starved.
- **Busy hold:** req 1 raises valid during req 0's WAIT → `req_ready_o[1]`=0 until IDLE; accepted in the cycle after req 0's RESP.
- **Timeout:** TIMEOUT=8, `mem_ready_i` tied low after ISSUE → `resp_valid_o` at T+10, `resp_error_o`=1, `resp_line_o`=0; next request is served normally.
- **Ready/timeout tie:** `mem_ready_i` rises exactly at `wait_cnt`=TIMEOUT-1 → `resp_error_o`=0 and the captured line is returned.
- **Reset mid-WAIT:** `rst_i` pulsed for one cycle during WAIT → no `resp_valid_o`; all outputs 0 the following cycle; `rr_ptr`=0, so requester 0 wins the next simultaneous request.
